// File: rtl/clock_set_controller.sv
// clock_set_controller: owns the 24-hour time-of-day word, runs it on a 1 kHz enable
// and lets the user freeze and step hours/minutes/seconds with an inactivity timeout.
module clock_set_controller #(
    parameter int TIMEOUT_TICKS = 10000,
    parameter int TO_W          = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ms_tick,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic        dec_btn,
    output logic [26:0] time_out,
    output logic [1:0]  field_sel,
    output logic        sec_pulse
);
    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] SET_HR  = 2'd1;
    localparam logic [1:0] SET_MIN = 2'd2;
    localparam logic [1:0] SET_SEC = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [4:0]      hr_q, hr_d;
    logic [5:0]      min_q, min_d, sec_q, sec_d;
    logic [9:0]      ms_q, ms_d;
    logic [TO_W-1:0] to_q, to_d;
    logic            sec_pulse_q, sec_pulse_d;
    logic            ms_wrap, sec_wrap, min_wrap, step;

    // Wrapping +/-1 at field width; top is the largest legal value of the field.
    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top, input logic up);
        return up ? ((v == top) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? top : v - 6'd1);
    endfunction

    assign ms_wrap  = ms_q == 10'd999;
    assign sec_wrap = ms_wrap && sec_q == 6'd59;
    assign min_wrap = sec_wrap && min_q == 6'd59;
    assign step     = inc_btn ^ dec_btn;

    always_comb begin
        state_d     = state_q;
        hr_d        = hr_q;
        min_d       = min_q;
        sec_d       = sec_q;
        ms_d        = ms_q;
        to_d        = to_q;
        sec_pulse_d = 1'b0;
        if (state_q == RUN) begin
            to_d = '0;
            if (mode_btn) state_d = SET_HR;
            else if (ms_tick) begin
                ms_d        = ms_wrap ? 10'd0 : ms_q + 10'd1;
                sec_pulse_d = ms_wrap;
                sec_d       = ms_wrap  ? wrap_step(sec_q, 6'd59, 1'b1) : sec_q;
                min_d       = sec_wrap ? wrap_step(min_q, 6'd59, 1'b1) : min_q;
                hr_d        = min_wrap ? 5'(wrap_step({1'b0, hr_q}, 6'd23, 1'b1)) : hr_q;
            end
        end else if (mode_btn || inc_btn || dec_btn) begin
            // Any button activity beats a coincident terminal timeout tick.
            to_d = '0;
            if (mode_btn) begin
                state_d = (state_q == SET_SEC) ? RUN : state_q + 2'd1;
                ms_d    = (state_q == SET_SEC) ? 10'd0 : ms_q;
            end else if (step) begin
                hr_d  = (state_q == SET_HR)  ? 5'(wrap_step({1'b0, hr_q}, 6'd23, inc_btn)) : hr_q;
                min_d = (state_q == SET_MIN) ? wrap_step(min_q, 6'd59, inc_btn) : min_q;
                sec_d = (state_q == SET_SEC) ? wrap_step(sec_q, 6'd59, inc_btn) : sec_q;
            end
        end else if (ms_tick) begin
            if (to_q == TO_W'(TIMEOUT_TICKS - 1)) begin
                state_d = RUN;
                ms_d    = 10'd0;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            hr_q        <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            ms_q        <= '0;
            to_q        <= '0;
            sec_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            ms_q        <= ms_d;
            to_q        <= to_d;
            sec_pulse_q <= sec_pulse_d;
        end
    end

    assign time_out  = {hr_q, min_q, sec_q, ms_q};
    assign field_sel = state_q;
    assign sec_pulse = sec_pulse_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// tb_clock_set_controller: directed vectors with hand-computed expectations for
// clock_set_controller, checked by immediate assertions.
module tb_clock_set_controller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ms_tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
    logic [26:0] time_out;
    logic [1:0]  field_sel;
    logic        sec_pulse;
    int          vectors = 0;
    int          miscompares = 0;
    int          pulses;

    clock_set_controller dut (
        .clk(clk), .rst_n(rst_n), .ms_tick(ms_tick), .mode_btn(mode_btn),
        .inc_btn(inc_btn), .dec_btn(dec_btn), .time_out(time_out),
        .field_sel(field_sel), .sec_pulse(sec_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] tv(input int h, input int m, input int s, input int ms);
        return 32'(h * 4194304 + m * 65536 + s * 1024 + ms);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs held; returns 1 ns after the edge.
    task automatic cyc(input logic t, input logic m, input logic i, input logic d);
        ms_tick = t; mode_btn = m; inc_btn = i; dec_btn = d;
        @(posedge clk);
        #1;
        ms_tick = 0; mode_btn = 0; inc_btn = 0; dec_btn = 0;
    endtask

    task automatic ticks(input int n, output int p);
        p = 0;
        for (int k = 0; k < n; k++) begin
            cyc(1, 0, 0, 0);
            p += int'(sec_pulse);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_time", 32'(time_out), 0);
        chk("reset_field", 32'(field_sel), 0);
        chk("reset_pulse", 32'(sec_pulse), 0);
        rst_n = 1'b1;
        // Free run through the first second.
        ticks(999, pulses);
        chk("run_999_time", 32'(time_out), tv(0, 0, 0, 999));
        chk("run_999_pulses", 32'(pulses), 0);
        cyc(1, 0, 0, 0);
        chk("run_1000_time", 32'(time_out), tv(0, 0, 1, 0));
        chk("run_1000_pulse", 32'(sec_pulse), 1);
        cyc(0, 0, 0, 0);
        chk("pulse_one_cycle", 32'(sec_pulse), 0);
        cyc(0, 0, 1, 1);
        chk("run_ignores_incdec", 32'(time_out), tv(0, 0, 1, 0));
        // Preload 23:59:59 via SET and roll over the day.
        cyc(0, 1, 0, 0);
        chk("enter_set_hr", 32'(field_sel), 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        chk("set_sec_field", 32'(field_sel), 3);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        chk("preload_time", 32'(time_out), tv(23, 59, 59, 0));
        chk("preload_run", 32'(field_sel), 0);
        ticks(1000, pulses);
        chk("day_wrap_time", 32'(time_out), 0);
        chk("day_wrap_pulses", 32'(pulses), 1);
        // mode, dec, mode, inc x61, mode, mode.
        cyc(0, 1, 0, 0);
        chk("seq_fs1", 32'(field_sel), 1);
        cyc(0, 0, 0, 1);
        chk("hr_dec_wrap", 32'(time_out), tv(23, 0, 0, 0));
        cyc(0, 1, 0, 0);
        chk("seq_fs2", 32'(field_sel), 2);
        for (int k = 0; k < 61; k++) cyc(0, 0, 1, 0);
        chk("min_inc61", 32'(time_out), tv(23, 1, 0, 0));
        cyc(0, 1, 0, 0);
        chk("seq_fs3", 32'(field_sel), 3);
        cyc(0, 1, 0, 0);
        chk("seq_fs0", 32'(field_sel), 0);
        chk("seq_time", 32'(time_out), tv(23, 1, 0, 0));
        // Simultaneous buttons in SET_MIN.
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 1);
        chk("incdec_min", 32'(time_out), tv(23, 1, 0, 0));
        chk("incdec_fs", 32'(field_sel), 2);
        cyc(0, 1, 1, 0);
        chk("mode_inc_fs", 32'(field_sel), 3);
        chk("mode_inc_min", 32'(time_out), tv(23, 1, 0, 0));
        cyc(0, 1, 0, 0);
        chk("back_run", 32'(field_sel), 0);
        // Timeout from SET_HR with a nonzero frozen ms.
        ticks(5, pulses);
        chk("ms5", 32'(time_out), tv(23, 1, 0, 5));
        cyc(1, 1, 0, 0);
        chk("mode_drops_tick", 32'(time_out), tv(23, 1, 0, 5));
        chk("to_enter_fs", 32'(field_sel), 1);
        ticks(9999, pulses);
        chk("to_9999_fs", 32'(field_sel), 1);
        chk("to_frozen", 32'(time_out), tv(23, 1, 0, 5));
        chk("set_no_pulse", 32'(pulses), 0);
        cyc(0, 0, 1, 0);
        chk("to_inc_hr", 32'(time_out), tv(0, 1, 0, 5));
        ticks(9999, pulses);
        chk("to_post_9999_fs", 32'(field_sel), 1);
        cyc(1, 0, 0, 0);
        chk("to_expire_fs", 32'(field_sel), 0);
        chk("to_expire_time", 32'(time_out), tv(0, 1, 0, 0));
        cyc(1, 0, 0, 0);
        chk("run_after_to", 32'(time_out), tv(0, 1, 0, 1));
        // Async reset mid-cycle in SET_SEC with hr=5.
        cyc(0, 1, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("pre_rst_fs", 32'(field_sel), 3);
        chk("pre_rst_time", 32'(time_out), tv(5, 1, 0, 1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_time", 32'(time_out), 0);
        chk("async_rst_fs", 32'(field_sel), 0);
        #2 rst_n = 1'b1;
        #3;
        cyc(1, 0, 0, 0);
        chk("post_rst_tick", 32'(time_out), tv(0, 0, 0, 1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Owns the 27-bit time-of-day word consumed by the display path (12-hour conversion, digit decode).
- In RUN, advances the word on a 1 kHz enable.
- In SET, freezes the word and lets the user select a field (hours, minutes, seconds) and step it up or down with pushbutton pulses.
- Returns to RUN on the user's mode press or on an inactivity timeout.

Parameters:
- TIMEOUT_TICKS, 10000: number of ms_tick pulses with no button activity in a SET state before forced return to RUN (10 s).
- TO_W, 14: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_TICKS.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- ms_tick  input  1  one-cycle enable at 1 kHz.
- mode_btn  input  1  one-cycle pulse (debounced upstream); enters or advances SET.
- inc_btn  input  1  one-cycle pulse; increments the selected field.
- dec_btn  input  1  one-cycle pulse; decrements the selected field.
- time_out  output  27  {hr[26:22] 0-23, min[21:16] 0-59, sec[15:10] 0-59, ms[9:0] 0-999}, binary, 24-hour.
- field_sel  output  2  0=RUN, 1=hr, 2=min, 3=sec; drives display blink.
- sec_pulse  output  1  one-cycle pulse when ms wraps 999->0 in RUN.

Behaviour:
- Reset: one clock domain, clk; asynchronous active-low reset rst_n.
  - Assertion of rst_n at any time, including mid-SET, forces: time_out=0, field_sel=0, sec_pulse=0, state RUN, timeout counter 0.
- All outputs are registered. An input event sampled on edge N is visible after edge N.
- States: RUN, SET_HR, SET_MIN, SET_SEC. field_sel encodes the state directly.
- RUN:
  - On ms_tick, ms increments.
  - ms 999->0 carries into sec and asserts sec_pulse for that cycle.
  - sec 59->0 carries into min; min 59->0 carries into hr; hr 23->0 wraps. No date carry.
  - Example: 23:59:59.999 + tick -> 00:00:00.000.
  - inc_btn and dec_btn are ignored.
  - mode_btn -> SET_HR. The ms_tick in the same cycle is dropped, and the time is frozen from that edge.
- SET_*:
  - ms_tick does not advance the time. It only increments the timeout counter.
  - inc_btn: selected field +1 mod range (hr mod 24, min/sec mod 60). No carry into other fields.
  - dec_btn: selected field -1 mod range; 0 -> 23 or 59. No borrow.
  - inc_btn and dec_btn in the same cycle: no change to the field, but the timeout counter is still cleared.
  - mode_btn: SET_HR->SET_MIN->SET_SEC->RUN.
    - Exiting SET_SEC clears ms to 0, so the clock restarts on a whole second.
  - mode_btn with inc/dec in the same cycle: mode wins, the step is dropped.
- Timeout:
  - Any button pulse in SET clears the counter.
  - When the counter reaches TIMEOUT_TICKS, go to RUN, clear ms, clear the counter.
  - A button pulse in the same cycle as the terminal tick wins: counter cleared, the button is acted on, and the state stays in SET.
  - The counter is held at 0 in RUN.
- Width rules: all field arithmetic is done at field width with explicit wrap compares. Values are never out of range after reset, so out-of-range inputs are impossible.
- sec_pulse is never asserted in SET states.

Test Plan:
- Reset then 1000 ms_tick -> time_out = {0,0,1,0}; sec_pulse high exactly one cycle, on the 1000th tick.
- Preload via SET to 23:59:59, exit, then 1000 ticks -> time_out=0 (hr=0,min=0,sec=0,ms=0); one sec_pulse.
- mode, dec, mode, inc×61, mode, mode from 00:00:00 -> hr=23, min=1, sec=0, ms=0, field_sel sequence 1,2,3,0.
- In SET_MIN, inc_btn and dec_btn together -> min unchanged; mode_btn together with inc_btn -> field_sel 2->3, min unchanged.
- In SET_HR, 9999 ticks then inc_btn, then 10000 ticks -> hr+1 and return to RUN exactly on the 10000th post-press tick; ms=0.
- rst_n low for 3 ns mid-cycle while in SET_SEC with hr=5 -> immediately time_out=0, field_sel=0; no clock edge required.
